dmem_arbiter: RTL and testbench

- Shares the single data memory between NUM_PORTS core-side requesters (per-core cache miss/writeback paths) in the multicore system.
- Grants one requester at a time, round-robin.
- Registers the request, drives the memory for exactly one cycle, then returns a registered response with a one-cycle ack pulse.
- Sits between the per-core cache controllers and the data memory (combinational read, negedge write).

---
 rtl/dmem_pkg.sv | 30 +++
 rtl/rr_picker.sv | 32 +++
 rtl/dmem_arbiter.sv | 151 +++++++++++++++
 tb/tb_dmem_arbiter.sv | 356 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory arbiter.
// Holds the funct3 size codes, the arbiter state encoding, the default
// memory depth and the latched request payload type.
package dmem_pkg;

  localparam int unsigned DATA_W        = 32;
  localparam int unsigned MASK_BITS     = 3;
  localparam int unsigned MEM_WORDS_DEF = 1024;

  localparam logic [MASK_BITS-1:0] MASK_B  = 3'b000;
  localparam logic [MASK_BITS-1:0] MASK_H  = 3'b001;
  localparam logic [MASK_BITS-1:0] MASK_W  = 3'b010;
  localparam logic [MASK_BITS-1:0] MASK_BU = 3'b100;
  localparam logic [MASK_BITS-1:0] MASK_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } arb_state_t;

  // One requester's payload as latched at grant time.
  typedef struct packed {
    logic                 wr;
    logic [DATA_W-1:0]    addr;
    logic [DATA_W-1:0]    wdata;
    logic [MASK_BITS-1:0] mask;
  } mem_req_t;

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin selector.
// Ports:
//   req     - per-port request vector
//   rr_ptr  - highest-priority port index for this pick
//   valid_c - any request present
//   gnt_c   - first requesting port scanning upward from rr_ptr (mod NUM_PORTS)
module rr_picker #(
  parameter int unsigned NUM_PORTS = 2,
  parameter int unsigned IDX_W     = 1
) (
  input  logic [NUM_PORTS-1:0] req,
  input  logic [IDX_W-1:0]     rr_ptr,
  output logic                 valid_c,
  output logic [IDX_W-1:0]     gnt_c
);

  // Scan from the farthest candidate back to rr_ptr so the nearest one wins.
  always_comb begin
    logic [IDX_W-1:0] cand;
    valid_c = 1'b0;
    gnt_c   = '0;
    cand    = '0;
    for (int k = int'(NUM_PORTS) - 1; k >= 0; k--) begin
      cand = IDX_W'((int'(rr_ptr) + k) % int'(NUM_PORTS));
      if (req[cand]) begin
        valid_c = 1'b1;
        gnt_c   = cand;
      end
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing one data memory among NUM_PORTS requesters.
// Each access: latch request (IDLE), drive memory one cycle (ACCESS),
// hold a one-cycle registered ack/err/rsp_rdata (RESP).
// Ports:
//   clk, reset (async, active-low)
//   req/req_wr/req_addr/req_wdata/req_mask - per-port request and payload
//   ack/err/rsp_rdata                      - registered response to granted port
//   mem_addr/mem_wdata/mem_mask/mem_wr_en/mem_rd_en/mem_rdata - memory side
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int unsigned NUM_PORTS = 2,
  parameter int unsigned MEM_WORDS = MEM_WORDS_DEF
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [NUM_PORTS-1:0]           req,
  input  logic [NUM_PORTS-1:0]           req_wr,
  input  logic [NUM_PORTS*DATA_W-1:0]    req_addr,
  input  logic [NUM_PORTS*DATA_W-1:0]    req_wdata,
  input  logic [NUM_PORTS*MASK_BITS-1:0] req_mask,
  output logic [NUM_PORTS-1:0]           ack,
  output logic [NUM_PORTS-1:0]           err,
  output logic [DATA_W-1:0]              rsp_rdata,
  output logic [DATA_W-1:0]              mem_addr,
  output logic [DATA_W-1:0]              mem_wdata,
  output logic [MASK_BITS-1:0]           mem_mask,
  output logic                           mem_wr_en,
  output logic                           mem_rd_en,
  input  logic [DATA_W-1:0]              mem_rdata
);

  localparam int unsigned IDX_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  arb_state_t       state;
  arb_state_t       state_nxt;
  logic [IDX_W-1:0] rr_ptr;
  logic [IDX_W-1:0] gnt;
  mem_req_t         lat;
  logic             oor;

  logic             pick_valid_c;
  logic [IDX_W-1:0] pick_gnt_c;
  mem_req_t         port_req_c [NUM_PORTS];
  mem_req_t         cand_c;
  logic             cand_oor_c;

  rr_picker #(
    .NUM_PORTS (NUM_PORTS),
    .IDX_W     (IDX_W)
  ) u_rr_picker (
    .req     (req),
    .rr_ptr  (rr_ptr),
    .valid_c (pick_valid_c),
    .gnt_c   (pick_gnt_c)
  );

  // Unpack flat per-port buses into payload records.
  always_comb begin
    port_req_c = '{default: '0};
    for (int i = 0; i < int'(NUM_PORTS); i++) begin
      port_req_c[i].wr    = req_wr[i];
      port_req_c[i].addr  = req_addr[DATA_W*i +: DATA_W];
      port_req_c[i].wdata = req_wdata[DATA_W*i +: DATA_W];
      port_req_c[i].mask  = req_mask[MASK_BITS*i +: MASK_BITS];
    end
  end

  // Candidate payload and its word-address range check.
  always_comb begin
    cand_c     = port_req_c[pick_gnt_c];
    cand_oor_c = ({2'b00, cand_c.addr[DATA_W-1:2]} >= DATA_W'(MEM_WORDS));
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state and memory-side decode; memory is only driven in ACCESS.
  always_comb begin
    state_nxt = state;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_mask  = '0;
    mem_wr_en = 1'b0;
    mem_rd_en = 1'b0;
    case (state)
      IDLE: begin
        if (pick_valid_c) begin
          state_nxt = ACCESS;
        end
      end
      ACCESS: begin
        state_nxt = RESP;
        mem_addr  = lat.addr;
        mem_wdata = lat.wdata;
        mem_mask  = lat.mask;
        mem_wr_en = lat.wr & ~oor;
        mem_rd_en = ~lat.wr & ~oor;
      end
      RESP: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Request latch, response registers and round-robin pointer.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rr_ptr    <= '0;
      gnt       <= '0;
      lat       <= '0;
      oor       <= 1'b0;
      ack       <= '0;
      err       <= '0;
      rsp_rdata <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_valid_c) begin
            gnt <= pick_gnt_c;
            lat <= cand_c;
            oor <= cand_oor_c;
          end
        end
        ACCESS: begin
          ack       <= NUM_PORTS'(1) << gnt;
          err       <= oor ? (NUM_PORTS'(1) << gnt) : '0;
          rsp_rdata <= (!lat.wr && !oor) ? mem_rdata : '0;
        end
        RESP: begin
          ack       <= '0;
          err       <= '0;
          rsp_rdata <= '0;
          rr_ptr    <= (gnt == IDX_W'(NUM_PORTS - 1)) ? '0 : gnt + IDX_W'(1);
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed scenarios followed by
// random multi-port traffic, checked every cycle against a transaction-level
// model (grant order, response timing, shadow memory contents).
module tb_dmem_arbiter;
  import dmem_pkg::*;

  localparam int unsigned NP = 2;
  localparam int unsigned MW = 1024;

  logic              clk;
  logic              reset;
  logic [NP-1:0]     req;
  logic [NP-1:0]     req_wr;
  logic [NP*32-1:0]  req_addr;
  logic [NP*32-1:0]  req_wdata;
  logic [NP*3-1:0]   req_mask;
  logic [NP-1:0]     ack;
  logic [NP-1:0]     err;
  logic [31:0]       rsp_rdata;
  logic [31:0]       mem_addr;
  logic [31:0]       mem_wdata;
  logic [2:0]        mem_mask;
  logic              mem_wr_en;
  logic              mem_rd_en;
  logic [31:0]       mem_rdata;

  dmem_arbiter #(.NUM_PORTS(NP), .MEM_WORDS(MW)) dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .req_wr    (req_wr),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_mask  (req_mask),
    .ack       (ack),
    .err       (err),
    .rsp_rdata (rsp_rdata),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_mask  (mem_mask),
    .mem_wr_en (mem_wr_en),
    .mem_rd_en (mem_rd_en),
    .mem_rdata (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Sized load/store semantics of the data memory.
  function automatic logic [31:0] load_val(input logic [31:0] w, input logic [1:0] off,
                                           input logic [2:0] m);
    logic [7:0]  b;
    logic [15:0] h;
    b = w[8*off +: 8];
    h = off[1] ? w[31:16] : w[15:0];
    case (m)
      MASK_B:  return {{24{b[7]}}, b};
      MASK_H:  return {{16{h[15]}}, h};
      MASK_W:  return w;
      MASK_BU: return {24'h0, b};
      MASK_HU: return {16'h0, h};
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic [31:0] store_val(input logic [31:0] w, input logic [1:0] off,
                                            input logic [2:0] m, input logic [31:0] d);
    logic [31:0] r;
    r = w;
    case (m)
      MASK_B: r[8*off +: 8] = d[7:0];
      MASK_H: if (off[1]) r[31:16] = d[15:0]; else r[15:0] = d[15:0];
      MASK_W: r = d;
      default: r = w;
    endcase
    return r;
  endfunction

  // Memory environment: combinational read, negedge write.
  logic [31:0] mem    [MW];
  logic [31:0] shadow [MW];

  assign mem_rdata = mem_rd_en ? load_val(mem[mem_addr[11:2]], mem_addr[1:0], mem_mask) : 32'h0;

  always @(negedge clk) begin
    if (mem_wr_en) mem[mem_addr[11:2]] = store_val(mem[mem_addr[11:2]], mem_addr[1:0], mem_mask, mem_wdata);
  end

  // Transaction model state and per-cycle expectations.
  int          total, bad;
  int          m_busy, m_port, m_ptr;
  logic        m_wr, m_oor;
  logic [31:0] m_addr, m_wdata, m_rdata;
  logic [2:0]  m_mask;
  logic [NP-1:0] e_ack, e_err;
  logic [31:0] e_rdata, e_maddr, e_wdata;
  logic [2:0]  e_mask;
  logic        e_rd, e_wr;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic poke(input int idx, input logic [31:0] v);
    mem[idx] = v;
    shadow[idx] = v;
  endtask

  task automatic set_port(input int p, input logic wr, input logic [31:0] a,
                          input logic [31:0] d, input logic [2:0] m);
    req[p] = 1'b1;
    req_wr[p] = wr;
    req_addr[32*p +: 32] = a;
    req_wdata[32*p +: 32] = d;
    req_mask[3*p +: 3] = m;
  endtask

  task automatic model_reset();
    m_busy = 0;
    m_ptr  = 0;
  endtask

  // One clock: advance the model on the edge, then compare outputs.
  task automatic step();
    bit found;
    @(posedge clk);
    e_ack = '0; e_err = '0; e_rdata = '0; e_rd = 1'b0; e_wr = 1'b0;
    e_maddr = '0; e_wdata = '0; e_mask = '0;
    found = 1'b0;
    if (!reset) begin
      model_reset();
    end else if (m_busy == 0) begin
      for (int k = 0; k < int'(NP); k++) begin
        if (!found && req[(m_ptr + k) % NP]) begin
          found  = 1'b1;
          m_port = (m_ptr + k) % NP;
        end
      end
      if (found) begin
        m_wr    = req_wr[m_port];
        m_addr  = req_addr[32*m_port +: 32];
        m_wdata = req_wdata[32*m_port +: 32];
        m_mask  = req_mask[3*m_port +: 3];
        m_oor   = (m_addr >> 2) >= 32'(MW);
        m_rdata = 32'h0;
        if (!m_oor) begin
          if (m_wr) shadow[m_addr[11:2]] = store_val(shadow[m_addr[11:2]], m_addr[1:0], m_mask, m_wdata);
          else m_rdata = load_val(shadow[m_addr[11:2]], m_addr[1:0], m_mask);
        end
        e_maddr = m_addr; e_wdata = m_wdata; e_mask = m_mask;
        e_rd = !m_wr && !m_oor;
        e_wr = m_wr && !m_oor;
        m_busy = 2;
      end
    end else if (m_busy == 2) begin
      e_ack   = NP'(1) << m_port;
      e_err   = m_oor ? e_ack : '0;
      e_rdata = m_rdata;
      m_busy  = 1;
    end else begin
      m_ptr  = (m_port + 1) % NP;
      m_busy = 0;
    end
    #1;
    chk("ack", 32'(ack), 32'(e_ack));
    chk("err", 32'(err), 32'(e_err));
    chk("rsp_rdata", rsp_rdata, e_rdata);
    chk("mem_rd_en", 32'(mem_rd_en), 32'(e_rd));
    chk("mem_wr_en", 32'(mem_wr_en), 32'(e_wr));
    chk("mem_addr", mem_addr, e_maddr);
    chk("mem_wdata", mem_wdata, e_wdata);
    chk("mem_mask", 32'(mem_mask), 32'(e_mask));
  endtask

  // Step until the model acks port p, check response, drop req, finish RESP.
  task automatic serve(input int p, input bit do_chk, input logic [31:0] exp_rd,
                       input logic exp_err, input string tag, output int n);
    bit seen;
    seen = 1'b0;
    n = 0;
    for (int i = 0; i < 12 && !seen; i++) begin
      step();
      n++;
      if (e_ack[p]) seen = 1'b1;
    end
    chk({tag, "_acked"}, 32'(seen), 32'd1);
    if (seen && do_chk) begin
      chk({tag, "_ack"}, 32'(ack[p]), 32'd1);
      chk({tag, "_rdata"}, rsp_rdata, exp_rd);
      chk({tag, "_err"}, 32'(err[p]), 32'(exp_err));
    end
    req[p] = 1'b0;
    step();
  endtask

  task automatic rand_req(input int p);
    logic [2:0]  masks [8];
    logic [31:0] a;
    masks = '{MASK_B, MASK_H, MASK_W, MASK_BU, MASK_HU, MASK_W, 3'b011, 3'b110};
    if ($urandom % 8 == 0) a = 32'h1000 | $urandom;
    else a = {20'h0, 10'($urandom % MW), 2'($urandom)};
    set_port(p, 1'($urandom % 2), a, $urandom, masks[$urandom % 8]);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1);
  end

  initial begin
    int n;
    int nacks;
    int order [8];
    logic [31:0] v;
    total = 0; bad = 0;
    reset = 1'b0;
    req = '0; req_wr = '0; req_addr = '0; req_wdata = '0; req_mask = '0;
    m_busy = 0; m_ptr = 0; m_port = 0; m_wr = 0; m_oor = 0;
    m_addr = '0; m_wdata = '0; m_rdata = '0; m_mask = '0;
    for (int i = 0; i < int'(MW); i++) begin
      v = $urandom;
      poke(i, v);
    end
    poke(4, 32'hDEADBEEF);
    poke(8, 32'h11223344);
    poke(20, 32'hCAFEF00D);
    poke(21, 32'h0BADF00D);

    // Single read, request already held while in reset
    set_port(0, 1'b0, 32'h10, 32'h0, MASK_W);
    step();
    step();
    reset = 1'b1;
    serve(0, 1'b1, 32'hDEADBEEF, 1'b0, "rd_single", n);
    chk("rd_latency", 32'(n), 32'd2);

    // Byte store then loads
    set_port(1, 1'b1, 32'h21, 32'h000000AB, MASK_B);
    serve(1, 1'b1, 32'h0, 1'b0, "sb", n);
    set_port(1, 1'b0, 32'h21, 32'h0, MASK_BU);
    serve(1, 1'b1, 32'h000000AB, 1'b0, "lbu", n);
    set_port(1, 1'b0, 32'h20, 32'h0, MASK_W);
    serve(1, 1'b1, 32'h1122AB44, 1'b0, "lw_after_sb", n);

    // Contention from reset, both ports requesting continuously
    reset = 1'b0;
    model_reset();
    step();
    set_port(0, 1'b0, 32'h10, 32'h0, MASK_W);
    set_port(1, 1'b0, 32'h20, 32'h0, MASK_W);
    step();
    reset = 1'b1;
    nacks = 0;
    for (int c = 1; c <= 12; c++) begin
      step();
      if (ack != '0 && nacks < 8) begin
        order[nacks] = ack[1] ? 1 : 0;
        nacks++;
      end
      for (int p = 0; p < int'(NP); p++) begin
        if (e_ack[p]) set_port(p, 1'b0, {20'h0, 10'($urandom % MW), 2'b00}, 32'h0, MASK_W);
      end
    end
    req = '0;
    chk("rr_ack_count", 32'(nacks), 32'd4);
    for (int i = 0; i < 4 && i < nacks; i++) chk("rr_order", 32'(order[i]), 32'(i % 2));
    step();
    step();

    // Out of range and last in-range word
    set_port(0, 1'b0, 32'h00001000, 32'h0, MASK_W);
    serve(0, 1'b1, 32'h0, 1'b1, "oor_rd", n);
    set_port(1, 1'b1, 32'hFFFFFFF0, 32'h55AA55AA, MASK_W);
    serve(1, 1'b1, 32'h0, 1'b1, "oor_wr", n);
    set_port(0, 1'b0, 32'h00000FFC, 32'h0, MASK_W);
    serve(0, 1'b1, shadow[1023], 1'b0, "last_word", n);

    // Reset during ACCESS of a port1 read aborts with no ack
    set_port(1, 1'b0, 32'h10, 32'h0, MASK_W);
    step();
    reset = 1'b0;
    model_reset();
    #1;
    chk("rst_ack", 32'(ack), 32'd0);
    chk("rst_rd_en", 32'(mem_rd_en), 32'd0);
    chk("rst_addr", mem_addr, 32'h0);
    chk("rst_rdata", rsp_rdata, 32'h0);
    step();
    step();
    reset = 1'b1;
    serve(1, 1'b1, 32'hDEADBEEF, 1'b0, "post_rst", n);
    chk("post_rst_latency", 32'(n), 32'd2);

    // Pointer returns to 0 on reset: port0 wins after reset even though port1 was next
    set_port(0, 1'b0, 32'h10, 32'h0, MASK_W);
    serve(0, 1'b0, 32'h0, 1'b0, "pre_ptr", n);
    reset = 1'b0;
    model_reset();
    step();
    set_port(0, 1'b0, 32'h50, 32'h0, MASK_W);
    set_port(1, 1'b0, 32'h54, 32'h0, MASK_W);
    step();
    reset = 1'b1;
    step();
    step();
    chk("ptr_reset_first", 32'(ack), 32'd1);
    chk("ptr_reset_rdata", rsp_rdata, 32'hCAFEF00D);
    req[0] = 1'b0;
    step();
    serve(1, 1'b1, 32'h0BADF00D, 1'b0, "ptr_reset_second", n);

    // Payload changed after the sample edge is ignored
    set_port(0, 1'b0, 32'h50, 32'h0, MASK_W);
    step();
    req_addr[31:0] = 32'h54;
    #1;
    chk("stable_addr", mem_addr, 32'h50);
    step();
    chk("stable_ack", 32'(ack), 32'd1);
    chk("stable_rdata", rsp_rdata, 32'hCAFEF00D);
    req[0] = 1'b0;
    step();

    // Random traffic
    for (int c = 0; c < 400; c++) begin
      for (int p = 0; p < int'(NP); p++) begin
        if (e_ack[p]) begin
          if ($urandom % 2 == 0) req[p] = 1'b0;
          else rand_req(p);
        end else if (!req[p] && ($urandom % 3 == 0)) begin
          rand_req(p);
        end
      end
      step();
    end
    for (int p = 0; p < int'(NP); p++) begin
      if (e_ack[p] || !req[p]) req[p] = 1'b0;
    end
    for (int c = 0; c < 12; c++) begin
      step();
      for (int p = 0; p < int'(NP); p++) begin
        if (e_ack[p]) req[p] = 1'b0;
      end
    end
    chk("drained_req", 32'(req), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
